// File: rtl/serial_adder_n.sv
// -----------------------------------------------------------------------------
// serial_adder_n
//   Multi-cycle adder/subtractor. WIDTH-bit operands are processed DIGIT bits
//   per clock with a registered carry between digits, trading latency for area.
//
//   Operation: a + b + cin (sub = 0) or a - b (sub = 1, cin ignored).
//   Subtraction is done as a + ~b + 1, so cout = 1 means "no borrow".
//
// Parameters
//   WIDTH  operand/result width in bits (>= 2)
//   DIGIT  bits processed per clock; must divide WIDTH exactly
//
// Ports
//   clk    in   rising-edge clock
//   reset  in   synchronous active-high reset, dominates all other inputs
//   start  in   request a new operation (only looked at in IDLE)
//   sub    in   0 = add, 1 = subtract
//   a, b   in   operands, captured on an accepted start
//   cin    in   carry-in for add mode, captured on an accepted start
//   sum    out  result, valid from done until the next accepted start
//   cout   out  final carry out
//   ovf    out  two's-complement overflow of the result
//   busy   out  high while digits are being processed
//   done   out  one-cycle pulse when sum/cout/ovf become valid
// -----------------------------------------------------------------------------
module serial_adder_n #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = $clog2(N) + 1;
    localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(N - 1);

    // Elaboration-time parameter sanity checks
    if (WIDTH < 2) begin : g_bad_width
        $fatal(1, "serial_adder_n: WIDTH must be at least 2");
    end
    if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
        $fatal(1, "serial_adder_n: DIGIT must divide WIDTH exactly");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [DIGIT:0]       digit_s;
    logic                 msb_cin_s;
    logic                 digit_ovf_s;
    logic [WIDTH+DIGIT-1:0] shift_wide_s;
    logic                 last_s;

    // Digit adder and overflow derivation for the current digit
    always_comb begin
        digit_s      = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
                     + {{DIGIT{1'b0}}, carry_q};
        // Carry into the top bit of this digit, recovered from its sum bit
        msb_cin_s    = digit_s[DIGIT-1] ^ a_q[DIGIT-1] ^ b_q[DIGIT-1];
        digit_ovf_s  = msb_cin_s ^ digit_s[DIGIT];
        // New digit enters from the MSB end; works even when DIGIT == WIDTH
        shift_wide_s = {digit_s[DIGIT-1:0], sum_q};
        last_s       = (cnt_q == LAST_DIGIT);
    end

    // State register and datapath registers (synchronous reset)
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (last_s) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and registered-output next values
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    cnt_d   = '0;
                end else begin
                    a_d     = a_q;
                end
            end
            S_RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = digit_s[DIGIT];
                cnt_d   = cnt_q + CNT_W'(1);
                sum_d   = shift_wide_s[WIDTH+DIGIT-1:DIGIT];
                if (last_s) begin
                    cout_d = digit_s[DIGIT];
                    ovf_d  = digit_ovf_s;
                end else begin
                    cout_d = cout_q;
                end
            end
            S_DONE: begin
                cnt_d = cnt_q;
            end
            default: begin
                cnt_d = '0;
            end
        endcase
        // Flags follow the state being entered so they are registered outputs
        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: doc/serial_adder_n.md
Name: serial_adder_n

Overview:
- Parametrised multi-cycle adder/subtractor. Processes WIDTH-bit operands DIGIT bits per clock, using a registered carry between digits.
- Successor to the single-cycle half-adder blocks. Adds a carry-in, a subtract mode, a signed-overflow flag and a start/busy/done handshake.
- Used where area matters more than latency, for example in the teaching datapath's ALU slow path.

Parameters:
- WIDTH, 8, operand and result width in bits; must be at least 2.
- DIGIT, 1, bits added per clock; must divide WIDTH exactly (elaboration-time check, fatal on violation).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; sampled only in IDLE.
- sub  input  1  0 = add (a + b + cin); 1 = subtract (a - b, cin ignored).
- a  input  WIDTH  operand A, captured on accepted start.
- b  input  WIDTH  operand B, captured on accepted start.
- cin  input  1  carry-in for add mode, captured on accepted start.
- sum  output  WIDTH  result, valid from done until the next accepted start.
- cout  output  1  final carry out; in subtract mode 1 = no borrow.
- ovf  output  1  two's-complement overflow of the final result.
- busy  output  1  high while the operation is in progress.
- done  output  1  one-cycle pulse when the result becomes valid.

Behaviour:
- Reset state: sum = 0, cout = 0, ovf = 0, busy = 0, done = 0, state IDLE, internal registers cleared.
- Reset dominates every other input in any state. Reset mid-operation aborts it; no done pulse is issued for the aborted operation.
- Let N = WIDTH / DIGIT.
- States and transitions:
  - IDLE: if start = 1, capture the operands, then go to RUN with busy = 1 from the next cycle.
  - RUN: one digit per cycle; after N digits go to DONE.
  - DONE: done = 1 and busy = 0 for exactly one cycle, then return to IDLE.
- Capture on accepted start:
  - Shift register A ← a.
  - Shift register B ← (sub ? ~b : b).
  - Carry register ← (sub ? 1 : cin).
  - Digit counter ← 0.
- Each RUN cycle:
  - {c, d} = A[DIGIT-1:0] + B[DIGIT-1:0] + carry, a (DIGIT+1)-bit result.
  - Carry ← c.
  - d enters the result shift register from the MSB end; A and B shift right by DIGIT.
  - Counter increments.
- After N RUN cycles:
  - sum holds the full result, least significant digit in sum[DIGIT-1:0].
  - cout = final carry.
  - ovf = carry into MSB XOR carry out of MSB. When DIGIT > 1, derive the carry into the MSB inside the last digit.
- Latency: start accepted at edge k; done high during cycle k+N+1, with sum/cout/ovf already valid in that cycle.
- sum, cout and ovf hold their values in IDLE until the next accepted start.
- They may show partial values while busy = 1 and must not be used then.
- start while busy = 1 or during DONE is ignored, with no queueing.
- start asserted in the same cycle done is high is ignored. It is accepted only in the following cycle, when the block is back in IDLE.
- Changes to a, b, sub or cin after capture have no effect on the operation in progress.
- All arithmetic is modulo 2^WIDTH; no state beyond cout and ovf is kept.

Test Plan:
- WIDTH=8, DIGIT=1, add: a=8'h0F, b=8'h01, cin=0 -> done 9 cycles after start; sum=8'h10, cout=0, ovf=0.
- Add with wrap: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1, ovf=0. Then a=8'h7F, b=8'h00, cin=1 -> sum=8'h80, cout=0, ovf=1.
- Subtract: sub=1, a=8'h05, b=8'h07 -> sum=8'hFE, cout=0 (borrow), ovf=0. Then sub=1, a=8'h80, b=8'h01 -> sum=8'h7F, cout=1, ovf=1.
- Handshake: pulse start again 3 cycles after the first start, and again in the done cycle -> both ignored. Exactly one done pulse; the result is from the first operands. A start one cycle after done is accepted.
- Reset mid-operation: assert reset 4 cycles into a RUN -> next cycle sum=0, busy=0, no done pulse. A following start of 8'h22+8'h11 gives 8'h33.
- WIDTH=16, DIGIT=4: a=16'hFFFF, b=16'h0001 -> done 5 cycles after start; sum=16'h0000, cout=1. A random sweep of 1000 operand pairs in both modes must match a reference model.
